key_rate_ctrl: RTL and testbench

//  Upstream control stage for the LED blinker. Takes one raw mechanical push-button and

---
 rtl/led_pkg.sv | 13 +
 rtl/key_sync.sv | 24 ++
 rtl/key_rate_ctrl.sv | 148 ++++++++++++++
 tb/tb_key_rate_ctrl.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/led_pkg.sv
// Shared types and defaults for the LED blinker control path.
package led_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DB_PRS,
        HELD,
        DB_REL
    } key_state_t;

    localparam int unsigned RATE_W_DEF = 2;

endpackage

// File: rtl/key_sync.sv
// Two-flop synchroniser for an asynchronous single-bit input.
module key_sync #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    // Capture stage followed by the resolved output stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/key_rate_ctrl.sv
// Push-button front end: debounce, short/long press classification,
// and the blinker's rate select and enable registers.
module key_rate_ctrl
    import led_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYC = 1000000,
    parameter int unsigned LONG_CYC     = 50000000,
    parameter int unsigned KEY_ACT_LOW  = 1,
    parameter int unsigned RATE_W       = RATE_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              key_in,
    output logic              key_level,
    output logic              key_press,
    output logic              key_release,
    output logic              key_long,
    output logic [RATE_W-1:0] rate_sel,
    output logic              blink_en
);

    localparam int unsigned DB_W   = $clog2(DEBOUNCE_CYC);
    localparam int unsigned HOLD_W = $clog2(LONG_CYC);
    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYC - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYC - 1);

    key_state_t        state, state_d;
    logic [DB_W-1:0]   db_cnt, db_cnt_d;
    logic [HOLD_W-1:0] hold_cnt, hold_cnt_d;
    logic [HOLD_W-1:0] hold_inc_c;
    logic              long_f, long_f_d;
    logic              level_d, press_d, release_d, long_d, en_d;
    logic [RATE_W-1:0] rate_d;
    logic              key_norm_c;
    logic              long_hit_c;
    logic              k;

    assign key_norm_c = (KEY_ACT_LOW != 0) ? ~key_in : key_in;
    assign hold_inc_c = (hold_cnt == HOLD_LAST) ? hold_cnt : hold_cnt + HOLD_W'(1);
    assign long_hit_c = (hold_cnt == HOLD_LAST) && !long_f;

    key_sync #(.RST_VAL(1'b0)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (key_norm_c),
        .q   (k)
    );

    // Next-state and next-output logic; release beats a coincident long pulse.
    always_comb begin
        state_d    = state;
        db_cnt_d   = db_cnt;
        hold_cnt_d = hold_cnt;
        long_f_d   = long_f;
        level_d    = key_level;
        press_d    = 1'b0;
        release_d  = 1'b0;
        long_d     = 1'b0;
        rate_d     = rate_sel;
        en_d       = blink_en;
        case (state)
            IDLE: begin
                if (k) begin
                    state_d  = DB_PRS;
                    db_cnt_d = '0;
                end
            end
            DB_PRS: begin
                if (!k) begin
                    state_d = IDLE;
                end else if (db_cnt == DB_LAST) begin
                    state_d    = HELD;
                    press_d    = 1'b1;
                    level_d    = 1'b1;
                    hold_cnt_d = '0;
                    long_f_d   = 1'b0;
                end else begin
                    db_cnt_d = db_cnt + DB_W'(1);
                end
            end
            HELD: begin
                hold_cnt_d = hold_inc_c;
                if (long_hit_c) begin
                    long_d   = 1'b1;
                    long_f_d = 1'b1;
                end
                if (!k) begin
                    state_d  = DB_REL;
                    db_cnt_d = '0;
                end
            end
            DB_REL: begin
                hold_cnt_d = hold_inc_c;
                if (!k && db_cnt == DB_LAST) begin
                    state_d   = IDLE;
                    release_d = 1'b1;
                    level_d   = 1'b0;
                    if (long_f) begin
                        en_d = ~blink_en;
                    end else begin
                        rate_d = rate_sel + RATE_W'(1);
                    end
                end else begin
                    if (k) begin
                        state_d = HELD;
                    end else begin
                        db_cnt_d = db_cnt + DB_W'(1);
                    end
                    if (long_hit_c) begin
                        long_d   = 1'b1;
                        long_f_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            db_cnt      <= '0;
            hold_cnt    <= '0;
            long_f      <= 1'b0;
            key_level   <= 1'b0;
            key_press   <= 1'b0;
            key_release <= 1'b0;
            key_long    <= 1'b0;
            rate_sel    <= '0;
            blink_en    <= 1'b1;
        end else begin
            state       <= state_d;
            db_cnt      <= db_cnt_d;
            hold_cnt    <= hold_cnt_d;
            long_f      <= long_f_d;
            key_level   <= level_d;
            key_press   <= press_d;
            key_release <= release_d;
            key_long    <= long_d;
            rate_sel    <= rate_d;
            blink_en    <= en_d;
        end
    end

endmodule

// File: tb/tb_key_rate_ctrl.sv
// Self-checking bench for key_rate_ctrl: hand-computed segment table,
// exact-latency and reset sequences, and randomised key activity
// checked cycle by cycle against a run-length reference model.
module tb_key_rate_ctrl;

    localparam int DEB    = 4;
    localparam int LONG   = 20;
    localparam int NRATES = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       key_in = 1'b1;
    logic       key_level, key_press, key_release, key_long, blink_en;
    logic [1:0] rate_sel;

    int total = 0;
    int bad   = 0;

    key_rate_ctrl #(
        .DEBOUNCE_CYC (DEB),
        .LONG_CYC     (LONG),
        .KEY_ACT_LOW  (1),
        .RATE_W       (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .key_in      (key_in),
        .key_level   (key_level),
        .key_press   (key_press),
        .key_release (key_release),
        .key_long    (key_long),
        .rate_sel    (rate_sel),
        .blink_en    (blink_en)
    );

    always #5 clk = ~clk;

    // Reference model: the accepted level flips once the synchronised key has
    // disagreed with it for DEB+1 consecutive cycles; a press turns long
    // LONG cycles after acceptance unless released on that very cycle.
    bit q1, q2, m_level, m_press, m_release, m_long, m_en, long_done;
    int run, age, m_rate;

    task automatic model_reset();
        q1 = 0; q2 = 0; m_level = 0; run = 0; age = 0; long_done = 0;
        m_press = 0; m_release = 0; m_long = 0; m_rate = 0; m_en = 1;
    endtask

    task automatic model_step();
        bit k;
        k  = q2;
        q2 = q1;
        q1 = (key_in == 1'b0);
        m_press = 0; m_release = 0; m_long = 0;
        run = (k != m_level) ? run + 1 : 0;
        if (m_level) age++;
        if (run == DEB + 1) begin
            run = 0;
            if (!m_level) begin
                m_level = 1; m_press = 1; age = 0; long_done = 0;
            end else begin
                m_level = 0; m_release = 1;
                if (long_done) m_en = !m_en;
                else m_rate = (m_rate + 1) % NRATES;
            end
        end else if (m_level && age == LONG && !long_done) begin
            m_long = 1; long_done = 1;
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    int  n_press, n_rel, n_long;
    bit  prev_press, prev_rel, prev_long;

    // One clock: drive the pressed level, step the model, check at negedge.
    task automatic tick(input bit p);
        key_in = ~p;
        @(posedge clk);
        if (rst) model_reset(); else model_step();
        @(negedge clk);
        chk("key_level",   key_level,   m_level);
        chk("key_press",   key_press,   m_press);
        chk("key_release", key_release, m_release);
        chk("key_long",    key_long,    m_long);
        chk("rate_sel",    rate_sel,    m_rate);
        chk("blink_en",    blink_en,    m_en);
        chk("pulse_exclusive", (int'(key_press) + int'(key_release) + int'(key_long)) <= 1, 1);
        chk("pulse_width", (key_press && prev_press) || (key_release && prev_rel) ||
                           (key_long && prev_long), 0);
        prev_press = key_press; prev_rel = key_release; prev_long = key_long;
        n_press += int'(key_press);
        n_rel   += int'(key_release);
        n_long  += int'(key_long);
    endtask

    typedef struct {
        bit p;
        int n;
        int press;
        int rel;
        int lng;
        int rate;
        bit en;
    } seg_t;

    seg_t tbl[19];

    initial begin
        int at;
        int r0;

        tbl[0]  = '{0, 10, 0, 0, 0, 0, 1};
        tbl[1]  = '{1,  3, 0, 0, 0, 0, 1};   // short bounce
        tbl[2]  = '{0, 10, 0, 0, 0, 0, 1};
        tbl[3]  = '{1,  4, 0, 0, 0, 0, 1};   // longest bounce still rejected
        tbl[4]  = '{0, 10, 0, 0, 0, 0, 1};
        tbl[5]  = '{1, 10, 1, 0, 0, 0, 1};
        tbl[6]  = '{0, 10, 0, 1, 0, 1, 1};
        tbl[7]  = '{1, 10, 1, 0, 0, 1, 1};
        tbl[8]  = '{0, 10, 0, 1, 0, 2, 1};
        tbl[9]  = '{1, 10, 1, 0, 0, 2, 1};
        tbl[10] = '{0, 10, 0, 1, 0, 3, 1};
        tbl[11] = '{1, 10, 1, 0, 0, 3, 1};
        tbl[12] = '{0, 10, 0, 1, 0, 0, 1};   // rate wraps
        tbl[13] = '{1, 30, 1, 0, 1, 0, 1};   // long press
        tbl[14] = '{0, 10, 0, 1, 0, 0, 0};   // enable toggles, rate kept
        tbl[15] = '{1, 10, 1, 0, 0, 0, 0};
        tbl[16] = '{0,  4, 0, 0, 0, 0, 0};   // release bounce
        tbl[17] = '{1,  4, 0, 0, 0, 0, 0};
        tbl[18] = '{0, 10, 0, 1, 0, 1, 0};

        prev_press = 0; prev_rel = 0; prev_long = 0;
        model_reset();

        // Asynchronous reset: outputs valid before any clock edge.
        #1 rst = 1'b1;
        #1;
        chk("rst_level", key_level, 0);
        chk("rst_press", key_press, 0);
        chk("rst_rate",  rate_sel,  0);
        chk("rst_en",    blink_en,  1);
        tick(0);
        tick(0);
        rst = 1'b0;

        // Hand-computed segment table.
        for (int s = 0; s < 19; s++) begin
            n_press = 0; n_rel = 0; n_long = 0;
            for (int c = 0; c < tbl[s].n; c++) tick(tbl[s].p);
            chk($sformatf("seg%0d_press", s), n_press,  tbl[s].press);
            chk($sformatf("seg%0d_rel", s),   n_rel,    tbl[s].rel);
            chk($sformatf("seg%0d_long", s),  n_long,   tbl[s].lng);
            chk($sformatf("seg%0d_rate", s),  rate_sel, tbl[s].rate);
            chk($sformatf("seg%0d_en", s),    blink_en, tbl[s].en);
        end

        // Exact press and release latency from a stable edge.
        at = 0;
        for (int i = 1; i <= 12; i++) begin
            tick(1);
            if (key_press && at == 0) at = i;
        end
        chk("press_latency", at, DEB + 3);
        r0 = rate_sel;
        at = 0;
        for (int i = 1; i <= 12; i++) begin
            tick(0);
            if (key_release && at == 0) at = i;
        end
        chk("release_latency", at, DEB + 3);
        chk("short_rate_step", rate_sel, (r0 + 1) % NRATES);

        // Randomised key activity against the model.
        for (int s = 0; s < 40; s++) begin
            bit p;
            int len;
            p   = 1'($urandom_range(0, 1));
            len = int'($urandom_range(1, 26));
            for (int c = 0; c < len; c++) tick(p);
        end
        for (int c = 0; c < 30; c++) tick(0);

        // Reset while held; the still-held key is a fresh press afterwards.
        for (int c = 0; c < 10; c++) tick(1);
        chk("held_level", key_level, 1);
        #2 rst = 1'b1;
        #1;
        chk("midrst_level", key_level, 0);
        chk("midrst_rate",  rate_sel,  0);
        chk("midrst_en",    blink_en,  1);
        model_reset();
        tick(1);
        tick(1);
        rst = 1'b0;
        at = 0;
        for (int i = 1; i <= 12; i++) begin
            tick(1);
            if (key_press && at == 0) at = i;
        end
        chk("repress_latency", at, DEB + 3);
        for (int c = 0; c < 12; c++) tick(0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
